// File: rtl/sram_bist_pkg.sv
// Shared encodings for the SRAM BIST controller: FSM states, mode values
// and the read-latency range check.
package sram_bist_pkg;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR   = 3'd1;
   localparam logic [2:0] S_TURN = 3'd2;
   localparam logic [2:0] S_RD   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_ADDR  = 1'b1;

   function automatic bit read_lat_ok(input int rl);
      return (rl >= 1) && (rl <= 3);
   endfunction

endpackage

// File: rtl/sram_bist_datagen.sv
// Expected-word generator: exp(a,p) = base ^ {DATA_W{p}}, base optionally
// XORed with the low address bits. Used for both write data and compare.
module sram_bist_datagen
   import sram_bist_pkg::*;
#(
   parameter int          ADDR_W  = 8,
   parameter int          DATA_W  = 4,
   parameter logic [31:0] PATTERN = 32'hA
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              p,
   input  logic              mode,
   output logic [DATA_W-1:0] exp_data
);

   localparam logic [DATA_W-1:0] PAT = DATA_W'(PATTERN);

   logic [DATA_W-1:0] addr_ext;
   logic [DATA_W-1:0] base;

   always_comb begin
      addr_ext = DATA_W'(addr);
      base     = (mode == MODE_ADDR) ? (PAT ^ addr_ext) : PAT;
      exp_data = base ^ {DATA_W{p}};
   end

endmodule

// File: rtl/sram_bist_ctrl.sv
// Two-pass (true, then inverted) write/read-back BIST for an asynchronous
// SRAM with a shared tri-state bus. All SRAM controls are registered.
module sram_bist_ctrl
   import sram_bist_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter int          DATA_W   = 4,
   parameter int          DEPTH    = 2**ADDR_W,
   parameter logic [31:0] PATTERN  = 32'hA,
   parameter int          READ_LAT = 1,
   parameter int          CNT_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_cs,
   output logic              sram_we,
   output logic              sram_oe
);

   // An out-of-range READ_LAT falls back to a single-cycle hold.
   localparam int                RL       = read_lat_ok(READ_LAT) ? READ_LAT : 1;
   localparam logic [1:0]        RL_LAST  = 2'(RL - 1);
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [2:0]        state;
   logic              p;
   logic              after_rd;
   logic              mode_q;
   logic              found;
   logic [1:0]        lat_cnt;
   logic [DATA_W-1:0] exp_data;
   logic              mismatch;

   sram_bist_datagen #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .PATTERN (PATTERN)
   ) u_datagen (
      .addr     (sram_addr),
      .p        (p),
      .mode     (mode_q),
      .exp_data (exp_data)
   );

   // sram_we is the registered drive enable, so the bus is only driven in WR.
   assign sram_data = sram_we ? exp_data : {DATA_W{1'bz}};
   assign mismatch  = (sram_data !== exp_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         p              <= 1'b0;
         after_rd       <= 1'b0;
         mode_q         <= MODE_FIXED;
         found          <= 1'b0;
         lat_cnt        <= 2'd0;
         sram_addr      <= '0;
         sram_cs        <= 1'b0;
         sram_we        <= 1'b0;
         sram_oe        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_WR;
                  p              <= 1'b0;
                  after_rd       <= 1'b0;
                  mode_q         <= mode;
                  found          <= 1'b0;
                  sram_addr      <= '0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  sram_cs        <= 1'b1;
                  sram_we        <= 1'b1;
               end
            end
            S_WR: begin
               if (sram_addr == LAST) begin
                  state     <= S_TURN;
                  after_rd  <= 1'b0;
                  sram_addr <= '0;
                  sram_cs   <= 1'b0;
                  sram_we   <= 1'b0;
               end else begin
                  sram_addr <= sram_addr + 1'b1;
               end
            end
            S_TURN: begin
               if (!after_rd) begin
                  state   <= S_RD;
                  lat_cnt <= 2'd0;
                  sram_cs <= 1'b1;
                  sram_oe <= 1'b1;
               end else if (!p) begin
                  state   <= S_WR;
                  p       <= 1'b1;
                  sram_cs <= 1'b1;
                  sram_we <= 1'b1;
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  pass  <= (err_count == '0);
               end
            end
            S_RD: begin
               if (lat_cnt == RL_LAST) begin
                  lat_cnt <= 2'd0;
                  if (mismatch) begin
                     if (err_count != CNT_MAX)
                        err_count <= err_count + 1'b1;
                     if (!found) begin
                        found          <= 1'b1;
                        first_err_addr <= sram_addr;
                     end
                  end
                  if (sram_addr == LAST) begin
                     state     <= S_TURN;
                     after_rd  <= 1'b1;
                     sram_addr <= '0;
                     sram_cs   <= 1'b0;
                     sram_oe   <= 1'b0;
                  end else begin
                     sram_addr <= sram_addr + 1'b1;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
